mem_arbiter: RTL
================

# mem_arbiter

Arbiter and sequencer for the single shared memory port of the minimal SoC. It sits between the CPU's instruction-fetch port and its data (load/store) port on one side and a single unified memory on the other. It serialises one transaction at a time, with data-over-fetch priority and a starvation guard for fetch. Requesters see a request/acknowledge handshake; the memory side sees a chip-enable/ready handshake.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `MAX_WAIT`, 4, consecutive data grants allowed while a fetch is pending (1..15)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `if_req` in 1: fetch request, held until `if_ack`
- `if_addr` in ADDR_W: fetch address, stable while `if_req`
- `if_rdata` out DATA_W: fetch read data, valid with `if_ack`
- `if_ack` out 1: one-cycle fetch completion pulse
- `d_req` in 1: data request, held until `d_ack`
- `d_we` in 1: 1 = store, 0 = load
- `d_sel` in 4: byte lane enables
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: store data
- `d_rdata` out DATA_W: load data, valid with `d_ack`
- `d_ack` out 1: one-cycle data completion pulse
- `mem_ce` out 1: memory access enable
- `mem_we` out 1: memory write enable
- `mem_sel` out 4: memory byte lanes
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory read data
- `mem_ready` in 1: memory completes the access this cycle

## Operation
- States: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- Arbitration in IDLE:
  - If `d_req` and `wait_cnt` < `MAX_WAIT`, go to BUSY_D.
  - Else if `if_req`, go to BUSY_I.
  - Else if `d_req`, go to BUSY_D.
  - Else stay in IDLE.
- Entering a BUSY state registers the winner's address, `we`, `sel` and `wdata` into the `mem_*` outputs.
  - Fetch uses `mem_we`=0 and `mem_sel`=4'b1111.
- In BUSY_x, `mem_ce`=1 and `mem_*` are held constant until the cycle `mem_ready`=1.
  - On that edge, `mem_rdata` is latched into `x_rdata` (loads and fetches only; for stores `d_rdata` holds its old value).
  - `x_ack` pulses for the next cycle.
  - `mem_ce`, `mem_we` and `mem_sel` clear.
  - State returns to IDLE.
- `wait_cnt` (4 bits):
  - Increments on each BUSY_D grant made while `if_req`=1.
  - Clears on a BUSY_I grant, or on any cycle with `if_req`=0.
  - Saturates at `MAX_WAIT`.
- Requester withdrawing `req` mid-transaction has no effect: the access completes and `ack` still pulses.
- `req` asserted in the `ack` cycle is treated as a new request.
- `mem_ready` is ignored in IDLE.
- Reset mid-transaction:
  - Immediately forces IDLE, `wait_cnt`=0 and all outputs to 0.
  - The transaction is abandoned and no `ack` is issued.

## Timing
- All outputs are registered. Reset value of every output is 0, including `if_rdata` and `d_rdata`.
- Request visible in IDLE at cycle N: `mem_ce`=1 from cycle N+1.
- If `mem_ready`=1 at cycle N+1 (zero-wait memory), `ack`=1 and rdata are valid at cycle N+2, and the state is IDLE at N+2.
- Each wait cycle of `mem_ready`=0 adds one cycle.
- Minimum turnaround: a new grant at the earliest in the `ack` cycle (IDLE). Peak throughput is one access per 2 cycles.
- `if_ack` and `d_ack` are never high in the same cycle. `mem_ce` is never high in IDLE.

## Test plan
- Reset then a single fetch, `if_addr`=0x10, memory returns 0x00A00093 with `mem_ready` at the first BUSY cycle:
  - `mem_ce`=1 at N+1 with `mem_addr`=0x10, `mem_we`=0.
  - `if_ack`=1 and `if_rdata`=0x00A00093 at N+2.
- Store with `d_addr`=0x100, `d_sel`=4'b0011, `d_wdata`=0xDEADBEEF, and 2 wait cycles:
  - `mem_*` stable for 3 cycles with `mem_we`=1 and `mem_sel`=0011.
  - `d_ack` one cycle after `mem_ready`.
  - `d_rdata` unchanged.
- `if_req` and `d_req` both asserted in the same IDLE cycle: data is granted first, fetch is granted in the IDLE cycle after `d_ack`.
- `d_req` held continuously with `if_req` high and `MAX_WAIT`=4: exactly 4 data grants, then 1 fetch grant, then data again; `wait_cnt` returns to 0.
- `rst` driven low while in BUSY_D with `mem_ready`=0:
  - Outputs are 0 asynchronously, before the next edge.
  - After release, the FSM is in IDLE and no `d_ack` is produced.
- Fetch request withdrawn one cycle after grant: the access completes, `if_ack` still pulses once, and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_sel;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_ce;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // slave: the arbiter itself; master: requesters plus memory around it
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, data-over-fetch priority with fetch starvation guard
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_t            state, state_nx;
  logic [3:0]        wait_cnt, wait_nx;
  logic              grant_i, grant_d;

  logic              ce_q, ce_nx;
  logic              we_q, we_nx;
  logic [3:0]        sel_q, sel_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_nx;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_nx;
  logic              if_ack_q, if_ack_nx;
  logic              d_ack_q, d_ack_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= wait_nx;
      ce_q       <= ce_nx;
      we_q       <= we_nx;
      sel_q      <= sel_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      if_rdata_q <= if_rdata_nx;
      d_rdata_q  <= d_rdata_nx;
      if_ack_q   <= if_ack_nx;
      d_ack_q    <= d_ack_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    ce_nx       = ce_q;
    we_nx       = we_q;
    sel_nx      = sel_q;
    addr_nx     = addr_q;
    wdata_nx    = wdata_q;
    if_rdata_nx = if_rdata_q;
    d_rdata_nx  = d_rdata_q;
    if_ack_nx   = 1'b0;
    d_ack_nx    = 1'b0;

    case (state)
      IDLE: begin
        // data wins unless fetch has already been passed over WAIT_LIM times
        if (bus.d_req && (wait_cnt < WAIT_LIM)) grant_d = 1'b1;
        else if (bus.if_req)                    grant_i = 1'b1;
        else if (bus.d_req)                     grant_d = 1'b1;

        if (grant_d) begin
          state_nx = BUSY_D;
          ce_nx    = 1'b1;
          we_nx    = bus.d_we;
          sel_nx   = bus.d_sel;
          addr_nx  = bus.d_addr;
          wdata_nx = bus.d_wdata;
        end else if (grant_i) begin
          state_nx = BUSY_I;
          ce_nx    = 1'b1;
          we_nx    = 1'b0;
          sel_nx   = 4'b1111;
          addr_nx  = bus.if_addr;
          wdata_nx = '0;
        end
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          state_nx    = IDLE;
          if_rdata_nx = bus.mem_rdata;
          if_ack_nx   = 1'b1;
          ce_nx       = 1'b0;
          we_nx       = 1'b0;
          sel_nx      = '0;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_nx = IDLE;
          if (!we_q) d_rdata_nx = bus.mem_rdata;
          d_ack_nx = 1'b1;
          ce_nx    = 1'b0;
          we_nx    = 1'b0;
          sel_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    wait_nx = wait_cnt;
    if (!bus.if_req || grant_i)                 wait_nx = '0;
    else if (grant_d && (wait_cnt < WAIT_LIM))  wait_nx = wait_cnt + 4'd1;
  end

  assign bus.mem_ce    = ce_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
endmodule
